rv32m_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit, sitting beside the single-cycle ALU in the execute stage. It accepts one operation per request under a start/busy/done handshake. It computes one result bit per cycle and returns a 32-bit result with fixed latency. The datapath stalls on `busy` and writes back `result` when `done` pulses.

---
 rtl/rv32m_muldiv_if.sv | 23 ++
 rtl/rv32m_muldiv.sv | 175 +++++++++++++++++
 tb/tb_rv32m_muldiv.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32m_muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M mul/div unit.
// Master drives start/op/operands; slave returns busy/done/result.
interface rv32m_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide, one result bit per cycle; RV32M_DIV_EN enables the divider.
// Latency: done in cycle 34 after accept (cycle 1 for compiled-out divide ops).
// Backpressure: start is only sampled when not busy; a start while busy is dropped.
module rv32m_muldiv #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  rv32m_muldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Operand signedness depends on the op: MULH/DIV/REM both, MULHSU rs1 only.
  logic            sign_a_in;
  logic            sign_b_in;
  logic [XLEN-1:0] abs_a_in;
  logic [XLEN-1:0] abs_b_in;

  always_comb begin
    sign_a_in = 1'b0;
    sign_b_in = 1'b0;
    case (bus.op)
      3'd1, 3'd4, 3'd6: begin
        sign_a_in = bus.a[XLEN-1];
        sign_b_in = bus.b[XLEN-1];
      end
      3'd2:    sign_a_in = bus.a[XLEN-1];
      default: ;
    endcase
  end

  assign abs_a_in = sign_a_in ? -bus.a : bus.a;
  assign abs_b_in = sign_b_in ? -bus.b : bus.b;

  // Shift-add: the product builds in the upper half while retired bits shift down.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] step_next;
  logic              bypass;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (opb[cnt] ? {1'b0, opa} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

`ifdef RV32M_DIV_EN
  // Restoring divide: acc = {partial remainder, quotient}, dividend fed MSB first.
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  assign div_trial = {acc[2*XLEN-1:XLEN], opa[LAST - cnt]};
  assign div_diff  = div_trial - {1'b0, opb};
  assign div_next  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
  assign step_next = op_q[2] ? div_next : mul_next;
  assign bypass    = 1'b0;
`else
  assign step_next = mul_next;
  assign bypass    = bus.op[2];
`endif

  logic              res_neg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fin_result;

  assign res_neg = sign_a ^ sign_b;
  assign prod    = res_neg ? -acc : acc;

`ifdef RV32M_DIV_EN
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] a_orig;
  logic            div_zero;
  logic            div_ovf;

  assign quo      = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem      = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign a_orig   = sign_a ? -opa : opa;
  assign div_zero = (opb == '0);
  // Only signed ops can set both signs, so this is the most-negative / -1 case.
  assign div_ovf  = sign_a && sign_b && (opa == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (opb == XLEN'(1));
`endif

  always_comb begin
    fin_result = '0;
    case (op_q)
      3'd0:             fin_result = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fin_result = prod[2*XLEN-1:XLEN];
`ifdef RV32M_DIV_EN
      3'd4, 3'd5: begin
        if (div_zero)     fin_result = '1;
        else if (div_ovf) fin_result = {1'b1, {(XLEN-1){1'b0}}};
        else              fin_result = quo;
      end
      3'd6, 3'd7: begin
        if (div_zero)     fin_result = a_orig;
        else if (div_ovf) fin_result = '0;
        else              fin_result = rem;
      end
`endif
      default: fin_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            sign_a <= sign_a_in;
            sign_b <= sign_b_in;
            opa    <= abs_a_in;
            opb    <= abs_b_in;
            acc    <= '0;
            cnt    <= '0;
            if (bypass) begin
              result_q <= '0;
              done_q   <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          acc <= step_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FINISH;
        end
        FINISH: begin
          result_q <= fin_result;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Scoreboard bench for rv32m_muldiv: directed vectors, handshake and reset-abort cases.
module tb_rv32m_muldiv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32m_muldiv_if #(.XLEN(32)) bus ();

  rv32m_muldiv #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    logic [2:0]  op;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected outcome for the build configuration: without the divider, ops 4-7 return 0 in cycle 1.
  task automatic exp_for(input logic [2:0] op, input logic [31:0] r,
                         output logic [31:0] er, output int lat);
`ifdef RV32M_DIV_EN
    er  = r;
    lat = 34;
`else
    er  = op[2] ? 32'd0 : r;
    lat = op[2] ? 1 : 34;
`endif
  endtask

  // Caller is at a negedge; request is accepted on the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input bit track);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    if (track) begin
      exp_for(op, r, e.res, e.lat);
      e.acc = cyc;
      e.op  = op;
      sb.push_back(e);
    end
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("result_op%0d", mon_e.op), bus.result, mon_e.res);
        check($sformatf("latency_op%0d", mon_e.op), 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
      end
    end
  end

  vec_t vecs[$];
  int   bad;
  logic exp_busy;

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;

    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14});
    vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2});
    vecs.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{3'd7, 32'd5,         32'd0,         32'd5});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB});
    vecs.push_back('{3'd0, 32'd3,         32'd4,         32'd12});

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7 x -3 with the busy window traced cycle by cycle.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) bad++;
    end
    check("busy_cycles_1_to_33", 32'(bad), 32'd0);
    @(negedge clk);
    check("busy_low_in_done_cycle", 32'(bus.busy), 32'd0);
    wait_drain();

    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, 1'b1);
      wait_drain();
    end

    // DIV 10/2: busy behaviour right after accept depends on the divider being present.
`ifdef RV32M_DIV_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    @(negedge clk);
    issue(3'd4, 32'd10, 32'd2, 32'd5, 1'b1);
    @(negedge clk);
    check("busy_after_div_accept", 32'(bus.busy), 32'(exp_busy));
    wait_drain();

    // Back-to-back: second start issued in the done cycle of the first.
    @(negedge clk);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    for (int i = 0; i < 60 && bus.done !== 1'b1; i++) @(negedge clk);
    check("b2b_first_done_seen", 32'(bus.done), 32'd1);
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
    wait_drain();

    // Start while busy must be dropped and operand changes ignored.
    @(negedge clk);
    issue(3'd3, 32'h1234_5678, 32'h0000_0010, 32'd1, 1'b1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);

    // Reset mid-operation aborts without a done pulse.
    issue(3'd0, 32'd5, 32'd6, 32'd30, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 32'd12, 1'b1);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
